// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction-side and data-side request
// channels, the backing-memory port, and the busy flag.
// The slave modport is the arbiter's view. The master modport is the view of
// whoever drives the requests and models the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // instruction side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // data side
  logic              d_req;
  logic              d_we;
  logic              d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // backing memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  // status
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_dout,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_din, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_dout,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between an
// instruction fetch side (read only) and a data side (writeback/refill).
// Each transaction takes ACC -> WAIT -> DONE. Contested grants alternate
// round-robin. A D grant made with d_lock high reserves the next IDLE grant
// for D, so that a writeback is followed by its refill.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

  state_t state;
  logic   owner_d;     // current transaction belongs to the D side
  logic   owner_we;    // current transaction is a write
  logic   lock;        // next IDLE grant is reserved for D
  logic   last_d;      // last round-robin grant went to D

  logic   grant_any;
  logic   grant_d;
  logic   lock_grant;

  // Arbitration decision for the IDLE state: lock first, then round-robin.
  always_comb begin
    grant_any  = bus.i_req | bus.d_req;
    lock_grant = lock & bus.d_req;
    if (lock_grant)
      grant_d = 1'b1;
    else if (bus.d_req && bus.i_req)
      grant_d = ~last_d;
    else
      grant_d = bus.d_req;
  end

  // Transaction FSM with registered memory-port, ack and read-data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      owner_we     <= 1'b0;
      lock         <= 1'b0;
      last_d       <= 1'b0;   // I counts as last winner, so D takes the first contest
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.mem_din  <= {DATA_W{1'b0}};
      bus.i_ack    <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.i_rdata  <= {DATA_W{1'b0}};
      bus.d_rdata  <= {DATA_W{1'b0}};
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= ACC;
            bus.busy   <= 1'b1;
            bus.mem_en <= 1'b1;
            owner_d    <= grant_d;
            // Only the winner's inputs reach the memory port.
            if (grant_d) begin
              owner_we     <= bus.d_we;
              bus.mem_we   <= bus.d_we;
              bus.mem_addr <= bus.d_addr;
              bus.mem_din  <= bus.d_wdata;
              lock         <= bus.d_lock;
            end else begin
              owner_we     <= 1'b0;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.i_addr;
              bus.mem_din  <= {DATA_W{1'b0}};
              lock         <= 1'b0;
            end
            // A reserved grant does not disturb the round-robin order.
            if (!lock_grant)
              last_d <= grant_d;
          end else begin
            // The reservation lapses if D is not asking in this IDLE.
            lock <= 1'b0;
          end
        end
        ACC: begin
          state      <= WAIT;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
        WAIT: begin
          state <= DONE;
          if (owner_d) begin
            bus.d_ack <= 1'b1;
            if (!owner_we)
              bus.d_rdata <= bus.mem_dout;
          end else begin
            bus.i_ack   <= 1'b1;
            bus.i_rdata <= bus.mem_dout;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A behavioural synchronous memory sits on the
// memory port. Each scenario pushes its expected acks (side, read data, cycle)
// into a scoreboard when it drives requests, and pops them when an ack appears.
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // backing memory model with a preload port
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_addr] <= pre_data;
    else if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr] <= bus.mem_din;
      else
        bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic              side_d;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.i_ack !== 1'b0 ||
        bus.d_ack !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: en=%b we=%b iack=%b dack=%b busy=%b, want all 0",
               bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.busy);
    end
    compared++;
    if (bus.mem_addr !== '0 || bus.mem_din !== '0 || bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      mismatched++;
      $display("FAIL reset_data: addr=%h din=%h irdata=%h drdata=%h, want all 0",
               bus.mem_addr, bus.mem_din, bus.i_rdata, bus.d_rdata);
    end
    rst = 1'b0;
    step();
    compared++;
    if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: busy=%b en=%b, want 0 0", bus.busy, bus.mem_en);
    end
  endtask

  task automatic test_single_read();
    exp_t e;
    logic [DATA_W-1:0] got;
    cyc = 0;
    bus.i_addr = 10'd5;
    bus.i_req  = 1'b1;
    sb.push_back('{side_d: 1'b0, data: 32'h0000_000A, cyc: 3});
    for (int k = 0; k < 8; k++) begin
      step();
      if (cyc == 1) begin
        compared++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'd5) begin
          mismatched++;
          $display("FAIL single_acc: en=%b we=%b addr=%0d, want 1 0 5", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
      end
      if (cyc == 2) begin
        compared++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b1) begin
          mismatched++;
          $display("FAIL single_wait: en=%b busy=%b, want 0 1", bus.mem_en, bus.busy);
        end
      end
      if (cyc == 4) begin
        compared++;
        if (bus.busy !== 1'b0 || bus.i_ack !== 1'b0) begin
          mismatched++;
          $display("FAIL single_idle: busy=%b iack=%b, want 0 0", bus.busy, bus.i_ack);
        end
      end
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL single_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          got = e.side_d ? bus.d_rdata : bus.i_rdata;
          $display("ack %s cyc=%0d rdata=%h", bus.d_ack ? "D" : "I", cyc, got);
          if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || got !== e.data) begin
            mismatched++;
            $display("FAIL single_ack: dack=%b cyc=%0d data=%h, want dack=%b cyc=%0d data=%h",
                     bus.d_ack, cyc, got, e.side_d, e.cyc, e.data);
          end
        end
        bus.i_req = 1'b0;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL single_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock();
    exp_t e;
    logic [DATA_W-1:0] got;
    int d_acks = 0;
    do_reset();
    cyc = 0;
    bus.i_addr  = 10'd5;
    bus.i_req   = 1'b1;
    bus.d_addr  = 10'd8;
    bus.d_wdata = 32'h3;
    bus.d_we    = 1'b1;
    bus.d_lock  = 1'b1;
    bus.d_req   = 1'b1;
    sb.push_back('{side_d: 1'b1, data: 32'h0, cyc: 3});
    sb.push_back('{side_d: 1'b1, data: 32'h55, cyc: 7});
    sb.push_back('{side_d: 1'b0, data: 32'h0000_000A, cyc: 11});
    for (int k = 0; k < 14; k++) begin
      step();
      if (cyc == 1) begin
        compared++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd8 || bus.mem_din !== 32'h3) begin
          mismatched++;
          $display("FAIL lock_wr_acc: en=%b we=%b addr=%h din=%h, want 1 1 008 00000003",
                   bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
      end
      if (cyc == 5) begin
        compared++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'h088) begin
          mismatched++;
          $display("FAIL lock_refill_acc: en=%b we=%b addr=%h, want 1 0 088", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
      end
      if (cyc == 9) begin
        compared++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd5) begin
          mismatched++;
          $display("FAIL lock_i_acc: en=%b addr=%h, want 1 005", bus.mem_en, bus.mem_addr);
        end
      end
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL lock_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          got = e.side_d ? bus.d_rdata : bus.i_rdata;
          $display("ack %s cyc=%0d rdata=%h", bus.d_ack ? "D" : "I", cyc, got);
          if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || got !== e.data) begin
            mismatched++;
            $display("FAIL lock_ack: dack=%b cyc=%0d data=%h, want dack=%b cyc=%0d data=%h",
                     bus.d_ack, cyc, got, e.side_d, e.cyc, e.data);
          end
        end
        if (bus.d_ack === 1'b1) begin
          d_acks++;
          if (d_acks == 1) begin
            bus.d_we   = 1'b0;
            bus.d_lock = 1'b0;
            bus.d_addr = 10'h088;
          end else
            bus.d_req = 1'b0;
        end
        if (bus.i_ack === 1'b1)
          bus.i_req = 1'b0;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL lock_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
    compared++;
    if (mem[8] !== 32'h3) begin
      mismatched++;
      $display("FAIL lock_mem_write: mem[8]=%h, want 00000003", mem[8]);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e;
    logic [DATA_W-1:0] got;
    int acks = 0;
    do_reset();
    cyc = 0;
    bus.d_we   = 1'b0;
    bus.d_lock = 1'b0;
    bus.d_addr = 10'h010;
    bus.i_addr = 10'h020;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    sb.push_back('{side_d: 1'b1, data: 32'h1111, cyc: 3});
    sb.push_back('{side_d: 1'b0, data: 32'h2222, cyc: 7});
    sb.push_back('{side_d: 1'b1, data: 32'h1111, cyc: 11});
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        acks++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL contend_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          got = e.side_d ? bus.d_rdata : bus.i_rdata;
          $display("ack %s cyc=%0d rdata=%h", bus.d_ack ? "D" : "I", cyc, got);
          if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || got !== e.data) begin
            mismatched++;
            $display("FAIL contend_ack: dack=%b cyc=%0d data=%h, want dack=%b cyc=%0d data=%h",
                     bus.d_ack, cyc, got, e.side_d, e.cyc, e.data);
          end
        end
        if (acks == 3) begin
          bus.d_req = 1'b0;
          bus.i_req = 1'b0;
        end
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL contend_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_early_drop();
    exp_t e;
    logic [DATA_W-1:0] got;
    cyc = 0;
    bus.d_we   = 1'b0;
    bus.d_lock = 1'b0;
    bus.d_addr = 10'h030;
    bus.d_req  = 1'b1;
    sb.push_back('{side_d: 1'b1, data: 32'h3333, cyc: 3});
    for (int k = 0; k < 10; k++) begin
      step();
      if (cyc == 1)
        bus.d_req = 1'b0;
      if (cyc == 6) begin
        compared++;
        if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
          mismatched++;
          $display("FAIL drop_regrant: busy=%b en=%b, want 0 0", bus.busy, bus.mem_en);
        end
      end
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL drop_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          got = e.side_d ? bus.d_rdata : bus.i_rdata;
          $display("ack %s cyc=%0d rdata=%h", bus.d_ack ? "D" : "I", cyc, got);
          if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || got !== e.data) begin
            mismatched++;
            $display("FAIL drop_ack: dack=%b cyc=%0d data=%h, want dack=%b cyc=%0d data=%h",
                     bus.d_ack, cyc, got, e.side_d, e.cyc, e.data);
          end
        end
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drop_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [DATA_W-1:0] got;
    int stray = 0;
    cyc = 0;
    bus.i_addr = 10'd5;
    bus.i_req  = 1'b1;
    step();
    step();   // now mid-WAIT
    #2 rst = 1'b1;
    #1;
    compared++;
    if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.i_ack !== 1'b0 ||
        bus.d_ack !== 1'b0 || bus.i_rdata !== '0) begin
      mismatched++;
      $display("FAIL async_reset: en=%b busy=%b iack=%b dack=%b irdata=%h, want 0 0 0 0 0",
               bus.mem_en, bus.busy, bus.i_ack, bus.d_ack, bus.i_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1 || bus.busy === 1'b1)
        stray++;
    end
    compared++;
    if (stray != 0) begin
      mismatched++;
      $display("FAIL async_no_ack: %0d cycles with ack/busy after abort, want 0", stray);
    end
    cyc = 0;
    bus.i_addr = 10'h020;
    bus.i_req  = 1'b1;
    sb.push_back('{side_d: 1'b0, data: 32'h2222, cyc: 3});
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL async_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          got = e.side_d ? bus.d_rdata : bus.i_rdata;
          $display("ack %s cyc=%0d rdata=%h", bus.d_ack ? "D" : "I", cyc, got);
          if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || got !== e.data) begin
            mismatched++;
            $display("FAIL async_fresh_ack: dack=%b cyc=%0d data=%h, want dack=%b cyc=%0d data=%h",
                     bus.d_ack, cyc, got, e.side_d, e.cyc, e.data);
          end
        end
        bus.i_req = 1'b0;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL async_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_write_keeps_rdata();
    exp_t e;
    logic              op_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [DATA_W-1:0] op_wd   [3] = '{32'h0, 32'h9, 32'h0};
    logic [DATA_W-1:0] op_want [3] = '{32'h7, 32'h7, 32'h9};
    logic done;
    for (int n = 0; n < 3; n++) begin
      cyc = 0;
      done = 1'b0;
      bus.d_we    = op_we[n];
      bus.d_wdata = op_wd[n];
      bus.d_lock  = 1'b0;
      bus.d_addr  = 10'h040;
      bus.d_req   = 1'b1;
      sb.push_back('{side_d: 1'b1, data: op_want[n], cyc: 3});
      for (int k = 0; k < 6 && !done; k++) begin
        step();
        if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL wr_extra_ack: iack=%b dack=%b at cyc %0d, want none", bus.i_ack, bus.d_ack, cyc);
          end else begin
            e = sb.pop_front();
            $display("ack %s op=%0d we=%b cyc=%0d d_rdata=%h", bus.d_ack ? "D" : "I", n, op_we[n], cyc, bus.d_rdata);
            if (bus.d_ack !== e.side_d || bus.i_ack === bus.d_ack || cyc != e.cyc || bus.d_rdata !== e.data) begin
              mismatched++;
              $display("FAIL wr_rdata op%0d: dack=%b cyc=%0d d_rdata=%h, want dack=%b cyc=%0d d_rdata=%h",
                       n, bus.d_ack, cyc, bus.d_rdata, e.side_d, e.cyc, e.data);
            end
          end
          bus.d_req = 1'b0;
          done = 1'b1;
        end
      end
      step();   // back to IDLE before the next request
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL wr_missing: %0d acks outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_lock   = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    @(negedge clk);
    preload(10'd5,   32'h0000_000A);
    preload(10'h088, 32'h55);
    preload(10'h010, 32'h1111);
    preload(10'h020, 32'h2222);
    preload(10'h030, 32'h3333);
    preload(10'h040, 32'h7);
    test_reset();
    test_single_read();
    test_lock();
    test_contention();
    test_early_drop();
    test_async_reset();
    test_write_keeps_rdata();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
